vector_sweep_checker: RTL

- Self-checking stimulus driver for the 4-input hazard circuit G = B·C + A'·C'·D.
- On start, drives all 16 ABCD combinations in order, waits a settle window per vector, samples the circuit output and compares it with the expected function.
- Reports a mismatch count, the first failing vector and pass/fail.
- Acts as the driving end of the circuit's A/B/C/D → G interface, for use in synthesizable self-test and benches.

---
 rtl/vector_sweep_checker_if.sv | 9 +
 rtl/vector_sweep_checker.sv | 129 ++++++++++++
 2 files changed

// File: rtl/vector_sweep_checker_if.sv
// Stimulus/response link between the sweep checker (master) and the
// 4-input circuit under test (slave): {A,B,C,D} out, G back.
interface vector_sweep_checker_if;
  logic [3:0] abcd_out;
  logic       g_in;

  modport master (output abcd_out, input g_in);
  modport slave  (input abcd_out, output g_in);
endinterface

// File: rtl/vector_sweep_checker.sv
// Exhaustive 16-vector sweep of G = B.C + A'.C'.D: drives each ABCD code,
// waits a settle window, samples the synchronized G and tallies mismatches.
module vector_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 4  // legal 3..15: 2 sync stages + propagation
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  vector_sweep_checker_if.master sweep,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [4:0]             err_count,
  output logic [3:0]             first_err_vec,
  output logic                   first_err_valid
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] abcd, abcd_n;
  logic [3:0] cnt, cnt_n;
  logic [4:0] err_n;
  logic [3:0] fev_n;
  logic       fvalid_n;
  logic       pass_n;
  logic [1:0] sync_q;
  logic       g_sync;
  logic       exp_g;
  logic       mismatch;

  assign sweep.abcd_out = abcd;
  assign g_sync         = sync_q[1];
  assign exp_g          = (abcd[2] & abcd[1]) | (~abcd[3] & ~abcd[1] & abcd[0]);
  assign mismatch       = g_sync ^ exp_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], sweep.g_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      abcd            <= '0;
      cnt             <= '0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
      pass            <= 1'b0;
    end else begin
      state           <= state_n;
      abcd            <= abcd_n;
      cnt             <= cnt_n;
      err_count       <= err_n;
      first_err_vec   <= fev_n;
      first_err_valid <= fvalid_n;
      pass            <= pass_n;
    end
  end

  always_comb begin
    state_n  = state;
    abcd_n   = abcd;
    cnt_n    = cnt;
    err_n    = err_count;
    fev_n    = first_err_vec;
    fvalid_n = first_err_valid;
    pass_n   = pass;
    busy     = (state != IDLE);
    done     = (state == DONE);

    case (state)
      IDLE: begin
        if (start) begin
          state_n  = SETTLE;
          abcd_n   = '0;
          cnt_n    = CNT_RELOAD;
          err_n    = '0;
          fev_n    = '0;
          fvalid_n = 1'b0;
          pass_n   = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          state_n = SAMPLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_n = err_count + 5'd1;
          if (!first_err_valid) begin
            fev_n    = abcd;
            fvalid_n = 1'b1;
          end
        end
        // pass is resolved from the post-sample count so it is already valid during DONE
        if (abcd == 4'hF) begin
          state_n = DONE;
          pass_n  = (err_n == 5'd0);
        end else begin
          abcd_n  = abcd + 4'd1;
          cnt_n   = CNT_RELOAD;
          state_n = SETTLE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
